// File: rtl/fx2_pkg.sv
// Shared definitions for the FX2 slave-FIFO scheduler.
package fx2_pkg;

   localparam logic [1:0] FIFOADR_EP2 = 2'b00;
   localparam logic [1:0] FIFOADR_EP6 = 2'b10;

   localparam int unsigned DEF_BLOCK_LEN = 512;
   localparam int unsigned DEF_PKT_SIZE  = 512;

   typedef enum logic [2:0] {
      StIdle,
      StRx,
      StTurn,
      StTx,
      StPktend,
      StDone
   } fx2_state_e;

endpackage

// File: rtl/fx2_tx_prefetch.sv
// Buffer read-ahead for the FIFO6 stream: keeps one byte in flight across the
// 1-cycle RAM latency and stalls with the FX2 full flag.
module fx2_tx_prefetch #(
   parameter int unsigned ADDR_W = 9
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_clr,
   input  logic              i_start,
   input  logic              i_active,
   input  logic              i_ready,
   input  logic [ADDR_W:0]   i_rx_count,
   output logic              o_wr,
   output logic              o_ren,
   output logic [ADDR_W-1:0] o_raddr
);

   localparam int unsigned CW = ADDR_W + 1;

   logic [CW-1:0] r_rd_ptr;
   logic          r_tx_valid;
   logic          w_more;

   // Write strobe and next read request; the RAM holds its output while stalled.
   always_comb begin
      o_wr    = i_active & r_tx_valid & i_ready;
      w_more  = (r_rd_ptr < i_rx_count);
      o_ren   = i_start | (o_wr & w_more);
      o_raddr = i_start ? '0 : r_rd_ptr[ADDR_W-1:0];
   end

   // Read pointer and "byte present on buf_rdata" flag.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rd_ptr   <= '0;
         r_tx_valid <= 1'b0;
      end else if (i_clr) begin
         r_rd_ptr   <= '0;
         r_tx_valid <= 1'b0;
      end else if (i_start) begin
         // Address 0 is fetched in the start cycle itself.
         r_rd_ptr   <= CW'(1);
         r_tx_valid <= 1'b1;
      end else if (o_wr) begin
         if (w_more) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end else begin
            r_tx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/fx2_fifo_sched.sv
// FX2 slave-FIFO scheduler: loads one block from EP2 into the buffer, turns the
// bus around and returns the block on EP6, closing short blocks with PKTEND.
module fx2_fifo_sched
   import fx2_pkg::*;
#(
   parameter int unsigned ADDR_W       = 9,
   parameter int unsigned BLOCK_LEN    = DEF_BLOCK_LEN,
   parameter int unsigned PKT_SIZE     = DEF_PKT_SIZE,
   parameter int unsigned TURN_CYC     = 2,
   parameter int unsigned IDLE_TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              soft_clr,
   input  logic              fifo2_data_available,
   input  logic              fifo6_ready,
   input  logic [7:0]        fifo_datain,
   output logic              fifo_rd,
   output logic              fifo_wr,
   output logic [1:0]        fifo_fifoadr,
   output logic              fifo_datain_oe,
   output logic              fifo_dataout_oe,
   output logic              fifo_pktend,
   output logic [7:0]        fifo_dataout,
   output logic              buf_wen,
   output logic [ADDR_W-1:0] buf_waddr,
   output logic [7:0]        buf_wdata,
   output logic              buf_ren,
   output logic [ADDR_W-1:0] buf_raddr,
   input  logic [7:0]        buf_rdata,
   output logic [ADDR_W:0]   rx_count,
   output logic              busy,
   output logic              block_done
);

   localparam int unsigned CW = ADDR_W + 1;
   localparam int unsigned IW = $clog2(IDLE_TIMEOUT + 1);
   localparam int unsigned TW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

   localparam logic [CW-1:0] RX_LAST   = CW'(BLOCK_LEN - 1);
   localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);
   localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYC - 1);

   fx2_state_e    r_state;
   fx2_state_e    w_state_nxt;
   logic [CW-1:0] r_wr_ptr;
   logic [CW-1:0] r_rx_count;
   logic [CW-1:0] r_tx_sent;
   logic [IW-1:0] r_idle_cnt;
   logic [TW-1:0] r_turn_cnt;
   logic          r_datain_oe;

   logic w_rx_rd;
   logic w_rx_full;
   logic w_rx_timeout;
   logic w_turn_last;
   logic w_tx_wr;
   logic w_tx_last;
   logic w_pkt_short;
   logic w_pf_clr;
   logic w_pf_ren;
   logic [ADDR_W-1:0] w_pf_raddr;

   // Transition conditions and next state.
   always_comb begin
      w_rx_rd      = (r_state == StRx) & fifo2_data_available;
      w_rx_full    = w_rx_rd & (r_rx_count == RX_LAST);
      w_rx_timeout = (r_state == StRx) & ~fifo2_data_available & (r_idle_cnt == IDLE_LAST);
      w_turn_last  = (r_state == StTurn) & (r_turn_cnt == TURN_LAST);
      w_tx_last    = w_tx_wr & ((r_tx_sent + 1'b1) == r_rx_count);
      w_pkt_short  = ((32'(r_rx_count) % PKT_SIZE) != 0);
      w_pf_clr     = soft_clr | (r_state == StDone);

      w_state_nxt = r_state;
      unique case (r_state)
         StIdle:   if (fifo2_data_available) w_state_nxt = StRx;
         StRx: begin
            if (w_rx_full) begin
               w_state_nxt = StTurn;
            end else if (w_rx_timeout) begin
               // An empty block has nothing to return.
               w_state_nxt = (r_rx_count != '0) ? StTurn : StIdle;
            end
         end
         StTurn:   if (w_turn_last) w_state_nxt = StTx;
         StTx:     if (w_tx_last) w_state_nxt = w_pkt_short ? StPktend : StDone;
         StPktend: if (fifo6_ready) w_state_nxt = StDone;
         StDone:   w_state_nxt = StIdle;
         default:  w_state_nxt = StIdle;
      endcase
   end

   // State register; soft_clr overrides every transition.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= StIdle;
         r_datain_oe <= 1'b0;
      end else if (soft_clr) begin
         r_state     <= StIdle;
         r_datain_oe <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_datain_oe <= (w_state_nxt == StIdle) | (w_state_nxt == StRx);
      end
   end

   // Block counters, cleared on soft_clr and at block completion.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr   <= '0;
         r_rx_count <= '0;
         r_tx_sent  <= '0;
         r_idle_cnt <= '0;
         r_turn_cnt <= '0;
      end else if (soft_clr || (r_state == StDone)) begin
         r_wr_ptr   <= '0;
         r_rx_count <= '0;
         r_tx_sent  <= '0;
         r_idle_cnt <= '0;
         r_turn_cnt <= '0;
      end else begin
         if (w_rx_rd) begin
            r_wr_ptr   <= r_wr_ptr + 1'b1;
            r_rx_count <= r_rx_count + 1'b1;
            r_idle_cnt <= '0;
         end else if (r_state == StRx) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
         end else begin
            r_idle_cnt <= '0;
         end
         if (r_state == StTurn) begin
            r_turn_cnt <= w_turn_last ? '0 : r_turn_cnt + 1'b1;
         end else begin
            r_turn_cnt <= '0;
         end
         if (w_tx_wr) begin
            r_tx_sent <= r_tx_sent + 1'b1;
         end
      end
   end

   fx2_tx_prefetch #(
      .ADDR_W (ADDR_W)
   ) u_prefetch (
      .i_clk      (clk),
      .i_rst_n    (reset_n),
      .i_clr      (w_pf_clr),
      .i_start    (w_turn_last),
      .i_active   (r_state == StTx),
      .i_ready    (fifo6_ready),
      .i_rx_count (r_rx_count),
      .o_wr       (w_tx_wr),
      .o_ren      (w_pf_ren),
      .o_raddr    (w_pf_raddr)
   );

   // FX2 and buffer port drive, decoded from state.
   always_comb begin
      fifo_fifoadr    = ((r_state == StIdle) || (r_state == StRx)) ? FIFOADR_EP2 : FIFOADR_EP6;
      fifo_rd         = w_rx_rd;
      fifo_wr         = w_tx_wr;
      fifo_dataout_oe = w_tx_wr;
      fifo_dataout    = buf_rdata;
      fifo_pktend     = (r_state == StPktend) & fifo6_ready;
      buf_wen         = w_rx_rd;
      buf_waddr       = r_wr_ptr[ADDR_W-1:0];
      buf_wdata       = fifo_datain;
      buf_ren         = w_pf_ren;
      buf_raddr       = w_pf_raddr;
      rx_count        = r_rx_count;
      busy            = (r_state != StIdle);
      block_done      = (r_state == StDone);
   end

   assign fifo_datain_oe = r_datain_oe;

endmodule

// File: tb/tb_fx2_fifo_sched.sv
// Directed bench: FX2 host and 512-byte buffer are modelled here; the DUT is
// driven 1 time unit after each rising edge and observed on the falling edge.
module tb_fx2_fifo_sched;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       soft_clr;
   logic       fifo2_data_available;
   logic       fifo6_ready;
   logic [7:0] fifo_datain;
   logic       fifo_rd;
   logic       fifo_wr;
   logic [1:0] fifo_fifoadr;
   logic       fifo_datain_oe;
   logic       fifo_dataout_oe;
   logic       fifo_pktend;
   logic [7:0] fifo_dataout;
   logic       buf_wen;
   logic [8:0] buf_waddr;
   logic [7:0] buf_wdata;
   logic       buf_ren;
   logic [8:0] buf_raddr;
   logic [7:0] buf_rdata;
   logic [9:0] rx_count;
   logic       busy;
   logic       block_done;

   always #5 clk = ~clk;

   fx2_fifo_sched dut (
      .clk                  (clk),
      .reset_n              (reset_n),
      .soft_clr             (soft_clr),
      .fifo2_data_available (fifo2_data_available),
      .fifo6_ready          (fifo6_ready),
      .fifo_datain          (fifo_datain),
      .fifo_rd              (fifo_rd),
      .fifo_wr              (fifo_wr),
      .fifo_fifoadr         (fifo_fifoadr),
      .fifo_datain_oe       (fifo_datain_oe),
      .fifo_dataout_oe      (fifo_dataout_oe),
      .fifo_pktend          (fifo_pktend),
      .fifo_dataout         (fifo_dataout),
      .buf_wen              (buf_wen),
      .buf_waddr            (buf_waddr),
      .buf_wdata            (buf_wdata),
      .buf_ren              (buf_ren),
      .buf_raddr            (buf_raddr),
      .buf_rdata            (buf_rdata),
      .rx_count             (rx_count),
      .busy                 (busy),
      .block_done           (block_done)
   );

   int errors = 0;
   int checks = 0;

   logic [7:0] mem  [512];
   logic [7:0] src  [512];
   logic [7:0] sink [512];
   int  src_len, src_idx, gap_at, gap_len, gap_cnt, cyc;
   bit  host_en, bp_mode, sclr, rd_pending, seen_ep6;
   logic [8:0] rd_addr;
   int  nrd, nwr, npkt, ndone, nturn, waddr_err, bad_wr, inv_err;
   int  last_rd_cyc, first_wr_cyc, last_wr_cyc, first_turn_cyc, pkt_cyc, turn_rx_count;
   int  guard;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // New host block: payload[i] = i*mul+add; monitor counters restart.
   task automatic load(input int len, input int mul, input int add);
      for (int i = 0; i < 512; i++) src[i] = 8'(i * mul + add);
      src_len = len; src_idx = 0; gap_at = -1; gap_len = 0; gap_cnt = 0; bp_mode = 0;
      nrd = 0; nwr = 0; npkt = 0; ndone = 0; nturn = 0; waddr_err = 0; bad_wr = 0;
      seen_ep6 = 0; last_rd_cyc = 0; first_wr_cyc = 0; last_wr_cyc = 0;
      first_turn_cyc = 0; pkt_cyc = 0; turn_rx_count = -1;
   endtask

   // One clock: drive inputs after the edge, observe and update models before the next.
   task automatic cycle();
      @(posedge clk);
      #1;
      soft_clr = sclr;
      fifo2_data_available = 1'b0;
      if (host_en && src_idx < src_len) begin
         if (src_idx == gap_at && gap_cnt < gap_len) gap_cnt++;
         else fifo2_data_available = 1'b1;
      end
      fifo_datain = (src_idx < src_len) ? src[src_idx] : 8'h00;
      fifo6_ready = bp_mode ? ((cyc % 4) == 3) : 1'b1;
      if (rd_pending) buf_rdata = mem[rd_addr];
      @(negedge clk);
      cyc++;
      if (fifo_rd && fifo_wr) inv_err++;
      if (fifo_datain_oe && fifo_dataout_oe) inv_err++;
      if (buf_wen) begin
         if (buf_waddr != 9'(nrd)) waddr_err++;
         mem[buf_waddr] = buf_wdata;
      end
      if (fifo_rd) begin nrd++; src_idx++; last_rd_cyc = cyc; end
      if (fifo_fifoadr == 2'b10 && !seen_ep6) begin
         seen_ep6 = 1; first_turn_cyc = cyc; turn_rx_count = int'(rx_count);
      end
      if (fifo_fifoadr == 2'b10 && nwr == 0 && !fifo_wr) nturn++;
      if (fifo_wr) begin
         if (!fifo6_ready) bad_wr++;
         if (nwr < 512) sink[nwr] = fifo_dataout;
         if (nwr == 0) first_wr_cyc = cyc;
         last_wr_cyc = cyc;
         nwr++;
      end
      if (fifo_pktend) begin npkt++; pkt_cyc = cyc; end
      if (block_done) ndone++;
      rd_pending = buf_ren;
      rd_addr    = buf_raddr;
   endtask

   task automatic run_block(input int limit);
      for (int i = 0; i < limit && ndone == 0; i++) cycle();
   endtask

   function automatic int count_bad(input int len);
      int bad = 0;
      for (int i = 0; i < len; i++) if (sink[i] !== src[i]) bad++;
      return bad;
   endfunction

   initial begin
      reset_n = 1'b0; soft_clr = 1'b0; sclr = 0; host_en = 0; bp_mode = 0; cyc = 0;
      fifo2_data_available = 1'b0; fifo6_ready = 1'b0; fifo_datain = 8'h00;
      buf_rdata = 8'h00; rd_pending = 0; rd_addr = '0; inv_err = 0;
      load(0, 0, 0);

      // Reset state
      #1;
      check("rst_busy", busy, 0);
      check("rst_rd", fifo_rd, 0);
      check("rst_wr", fifo_wr, 0);
      check("rst_adr", fifo_fifoadr, 0);
      check("rst_in_oe", fifo_datain_oe, 0);
      check("rst_out_oe", fifo_dataout_oe, 0);
      check("rst_pktend", fifo_pktend, 0);
      check("rst_done", block_done, 0);
      check("rst_rxcnt", rx_count, 0);
      check("rst_wen", buf_wen, 0);
      check("rst_ren", buf_ren, 0);
      #20 reset_n = 1'b1;

      // Full 512-byte block, no backpressure
      load(512, 1, 0);
      host_en = 1;
      run_block(3000);
      check("full_done", ndone, 1);
      check("full_nrd", nrd, 512);
      check("full_nwr", nwr, 512);
      check("full_turn", nturn, 2);
      check("full_turn_entry", first_turn_cyc - last_rd_cyc, 1);
      check("full_rxcnt", turn_rx_count, 512);
      check("full_consec", last_wr_cyc - first_wr_cyc, 511);
      check("full_pktend", npkt, 0);
      check("full_data", count_bad(512), 0);
      check("full_waddr", waddr_err, 0);
      cycle();
      check("post_busy", busy, 0);
      check("post_adr", fifo_fifoadr, 0);
      check("post_rxcnt", rx_count, 0);
      cycle(); cycle();
      check("full_done_once", ndone, 1);

      // Short block closed by the idle timeout
      load(37, 3, 17);
      run_block(1000);
      check("short_done", ndone, 1);
      check("short_rxcnt", turn_rx_count, 37);
      check("short_timeout", first_turn_cyc - last_rd_cyc, 65);
      check("short_nwr", nwr, 37);
      check("short_pktend", npkt, 1);
      check("short_pkt_pos", pkt_cyc - last_wr_cyc, 1);
      check("short_data", count_bad(37), 0);

      // TX backpressure 3 low / 1 high
      load(512, 5, 7);
      bp_mode = 1;
      run_block(5000);
      check("bp_done", ndone, 1);
      check("bp_nwr", nwr, 512);
      check("bp_wr_ready", bad_wr, 0);
      check("bp_data", count_bad(512), 0);
      check("bp_pktend", npkt, 0);

      // RX gap of 10 cycles at byte 100
      load(512, 1, 85);
      gap_at = 100; gap_len = 10;
      run_block(3000);
      check("gap_done", ndone, 1);
      check("gap_nrd", nrd, 512);
      check("gap_rxcnt", turn_rx_count, 512);
      check("gap_waddr", waddr_err, 0);
      check("gap_data", count_bad(512), 0);

      // soft_clr mid-TX at byte 200
      load(512, 11, 1);
      guard = 0;
      while (nwr < 200 && guard < 3000) begin cycle(); guard++; end
      check("sclr_reach", nwr, 200);
      host_en = 0;
      sclr = 1; cycle(); sclr = 0; cycle();
      check("sclr_busy", busy, 0);
      check("sclr_wr", fifo_wr, 0);
      check("sclr_rd", fifo_rd, 0);
      check("sclr_pktend", fifo_pktend, 0);
      check("sclr_out_oe", fifo_dataout_oe, 0);
      check("sclr_adr", fifo_fifoadr, 0);
      check("sclr_rxcnt", rx_count, 0);
      for (int i = 0; i < 5; i++) cycle();
      check("sclr_no_done", ndone, 0);
      load(512, 13, 2);
      host_en = 1;
      run_block(3000);
      check("sclr_next_done", ndone, 1);
      check("sclr_next_nwr", nwr, 512);
      check("sclr_next_data", count_bad(512), 0);

      // Async reset between edges during RX
      load(512, 1, 128);
      guard = 0;
      while (nrd < 50 && guard < 1000) begin cycle(); guard++; end
      check("arst_reach", nrd, 50);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("arst_busy", busy, 0);
      check("arst_rd", fifo_rd, 0);
      check("arst_wen", buf_wen, 0);
      check("arst_adr", fifo_fifoadr, 0);
      check("arst_in_oe", fifo_datain_oe, 0);
      check("arst_rxcnt", rx_count, 0);
      #20;
      load(512, 17, 3);
      reset_n = 1'b1;
      run_block(3000);
      check("arst_next_done", ndone, 1);
      check("arst_next_nrd", nrd, 512);
      check("arst_next_nwr", nwr, 512);
      check("arst_next_data", count_bad(512), 0);
      check("arst_next_pktend", npkt, 0);

      check("invariants", inv_err, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fx2_fifo_sched.md
Name: fx2_fifo_sched

Overview:
Scheduler for the FX2 slave-FIFO port and the 512-byte block buffer (dpram).
- Drains one block from FIFO2 (EP2, host->FPGA) into the buffer.
- Performs the bus turnaround to FIFO6.
- Streams the block back out to FIFO6 (EP6, FPGA->host), committing short packets with PKTEND.
- Replaces the free-running inline state decode in the top level. All FX2 signals are positive logic; the top level keeps the active-low inversions.

Parameters:
ADDR_W, 9, buffer address width
BLOCK_LEN, 512, bytes per block (<= 2**ADDR_W)
PKT_SIZE, 512, FX2 EP6 packet size; PKTEND is issued when a block is not a multiple of this
TURN_CYC, 2, turnaround cycles between FIFO2 and FIFO6 access (>=1)
IDLE_TIMEOUT, 64, consecutive RX-empty cycles after which a partial block is committed

Ports:
clk  in  1  FX2 interface clock (FIFO_CLK)
reset_n  in  1  asynchronous, active-low reset
soft_clr  in  1  synchronous clear (EP1 reset via FX2_PA_0), active high
fifo2_data_available  in  1  FIFO2 not empty
fifo6_ready  in  1  FIFO6 not full
fifo_datain  in  8  FX2 FD bus input
fifo_rd  out  1  SLRD strobe
fifo_wr  out  1  SLWR strobe
fifo_fifoadr  out  2  00=FIFO2, 10=FIFO6
fifo_datain_oe  out  1  FX2 drives FD
fifo_dataout_oe  out  1  FPGA drives FD
fifo_pktend  out  1  PKTEND strobe
fifo_dataout  out  8  byte to FX2
buf_wen  out  1  buffer write enable
buf_waddr  out  ADDR_W  buffer write address
buf_wdata  out  8  buffer write data
buf_ren  out  1  buffer read enable
buf_raddr  out  ADDR_W  buffer read address
buf_rdata  in  8  buffer read data; valid 1 cycle after buf_ren, held while buf_ren=0
rx_count  out  ADDR_W+1  bytes in current block
busy  out  1  high in every state except IDLE
block_done  out  1  one-cycle pulse when a block has been fully returned

Behaviour:
- Reset (reset_n=0, async) and soft_clr (sync, priority over all transitions):
  - state=IDLE; all strobes and OEs = 0; fifoadr=00.
  - wr_ptr = rd_ptr = rx_count = idle_cnt = 0; tx_valid=0; block_done=0.
- IDLE:
  - fifoadr=00, datain_oe=1.
  - fifo2_data_available=1 -> RX.
- RX:
  - fifoadr=00, datain_oe=1.
  - fifo_rd = fifo2_data_available.
  - On each cycle with fifo_rd=1: buf_wen=1, buf_waddr=wr_ptr, buf_wdata=fifo_datain (combinational pass-through, same cycle); wr_ptr++, rx_count++; idle_cnt=0.
  - Available=0: idle_cnt++.
  - Leave for TURN when either:
    - a write lands with rx_count reaching BLOCK_LEN (the last byte is written in that cycle), or
    - idle_cnt reaches IDLE_TIMEOUT (rx_count>=1 is guaranteed).
  - No read occurs after BLOCK_LEN bytes.
- TURN:
  - fifoadr=10; both OEs=0; no strobes; lasts exactly TURN_CYC cycles.
  - Final TURN cycle: buf_ren=1, buf_raddr=0, rd_ptr<=1, tx_valid<=1.
- TX:
  - fifoadr=10.
  - fifo_wr = tx_valid & fifo6_ready; dataout_oe = fifo_wr; fifo_dataout = buf_rdata.
  - On fifo_wr:
    - tx_sent++.
    - If rd_ptr<rx_count: buf_ren=1, buf_raddr=rd_ptr, rd_ptr++ (tx_valid stays 1).
    - Else: tx_valid<=0.
  - fifo6_ready=0: no write, no ren, pointers held; buf_rdata is held by the RAM.
  - After the write with tx_sent==rx_count:
    - rx_count%PKT_SIZE != 0 -> PKTEND.
    - Otherwise -> DONE.
- PKTEND:
  - fifoadr=10; fifo_pktend = fifo6_ready; wait while fifo6_ready=0.
  - -> DONE after the strobe.
- DONE:
  - block_done=1 for one cycle.
  - Clear wr_ptr, rd_ptr, rx_count, tx_sent, idle_cnt.
  - -> IDLE.
- Invariants:
  - fifo_rd and fifo_wr are never both high.
  - datain_oe and dataout_oe are never both high.
  - fifoadr changes only in the IDLE/RX->TURN and DONE->IDLE transitions.
- Counters are ADDR_W+1 bits. wr_ptr/rd_ptr index the buffer with their low ADDR_W bits; there is no wrap within a block.

Decomposition:
- Shared package fx2_pkg:
  - FIFOADR_EP2=2'b00, FIFOADR_EP6=2'b10.
  - state enum: IDLE, RX, TURN, TX, PKTEND, DONE.
  - default BLOCK_LEN/PKT_SIZE.
- One natural sub-module: fx2_tx_prefetch. It holds tx_valid, rd_ptr and buf_ren generation over the 1-cycle RAM latency, with stall on fifo6_ready.

Test Plan:
- Full block:
  - Stimulus: host sends 512 bytes 0x00..0xFF,0x00..0xFF; fifo6_ready=1.
  - Required: 512 fifo_rd, TURN 2 cycles, 512 fifo_wr in consecutive cycles, same byte order, no PKTEND, block_done once.
- Short block:
  - Stimulus: 37 bytes, then FIFO2 empty for 64 cycles.
  - Required: TURN entered at idle_cnt=64, rx_count=37, 37 writes, then one fifo_pktend pulse, block_done.
- TX backpressure:
  - Stimulus: fifo6_ready toggles 3 low / 1 high during TX of 512 bytes.
  - Required: output stream identical, fifo_wr only when ready=1, no duplicated or dropped byte.
- RX gaps:
  - Stimulus: data_available drops for 10 cycles at byte 100 (below timeout).
  - Required: RX continues, buf_waddr contiguous, total 512.
- soft_clr mid-TX at byte 200:
  - Required: next cycle state=IDLE, all strobes 0, fifoadr=00, rx_count=0, no block_done.
  - Following block: returned correctly.
- Async reset:
  - Stimulus: reset_n=0 between clock edges during RX.
  - Required: outputs cleared immediately, without waiting for a clock edge.
  - On release: IDLE, and a new block is processed normally.
